// File: rtl/cpu_stack_if.sv
// Operation/status bundle between the CPU core (master) and one stack instance (slave).
interface cpu_stack_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]    op;
  logic [DW-1:0] din;
  logic          clr_flags;
  logic [DW-1:0] tos;
  logic [DW-1:0] nos;
  logic [AW:0]   count;
  logic [AW:0]   hwm;
  logic          ovf;
  logic          unf;
  logic          err;

  modport master (output op, din, clr_flags,
                  input  tos, nos, count, hwm, ovf, unf, err);
  modport slave  (input  op, din, clr_flags,
                  output tos, nos, count, hwm, ovf, unf, err);
endinterface

// File: rtl/cpu_stack_unit.sv
// Single-cycle stack: TOS/NOS in registers, deeper entries in a synchronous RAM
// whose read port is addressed from the next count so a pop never stalls.
module cpu_stack_unit #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  cpu_stack_if.slave  sif
);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_REPL     = 3'd3,
    OP_POP_REPL = 3'd4,
    OP_SWAP     = 3'd5,
    OP_ROT      = 3'd6,
    OP_OVER     = 3'd7
  } op_e;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_THR  = (AW+1)'(3);

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] tos_q, tos_d;
  logic [DW-1:0] nos_q, nos_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   hwm_q, hwm_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_q, rd_d;

  logic          we;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [DW-1:0] wd;
  logic          rej_o, rej_u;
  logic          has1, has2, has3, full;
  logic [DW-1:0] nos_fill;
  op_e           op;

  always_comb begin
    op       = op_e'(sif.op);
    has1     = cnt_q >= CNT_ONE;
    has2     = cnt_q >= CNT_TWO;
    has3     = cnt_q >= CNT_THR;
    full     = cnt_q == CNT_FULL;
    // Entry that becomes NOS after a pop: RAM[count-3] prefetched last cycle, else empty.
    nos_fill = has3 ? rd_q : '0;

    tos_d = tos_q;
    nos_d = nos_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    wa    = cnt_q[AW-1:0] - AW'(2);
    wd    = nos_q;
    rej_o = 1'b0;
    rej_u = 1'b0;

    case (op)
      OP_PUSH: begin
        if (full) rej_o = 1'b1;
        else begin
          tos_d = sif.din;
          nos_d = tos_q;
          cnt_d = cnt_q + CNT_ONE;
          we    = has2;
        end
      end
      OP_POP: begin
        if (!has1) rej_u = 1'b1;
        else begin
          tos_d = nos_q;
          nos_d = nos_fill;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      OP_REPL: begin
        if (!has1) rej_u = 1'b1;
        else tos_d = sif.din;
      end
      OP_POP_REPL: begin
        if (!has2) rej_u = 1'b1;
        else begin
          tos_d = sif.din;
          nos_d = nos_fill;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      OP_SWAP: begin
        if (!has2) rej_u = 1'b1;
        else begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
      end
      OP_ROT: begin
        // a b c -> b c a: the third entry surfaces, old NOS sinks into its RAM slot.
        if (!has3) rej_u = 1'b1;
        else begin
          tos_d = rd_q;
          nos_d = tos_q;
          we    = 1'b1;
          wa    = cnt_q[AW-1:0] - AW'(3);
        end
      end
      OP_OVER: begin
        if (!has2) rej_u = 1'b1;
        else if (full) rej_o = 1'b1;
        else begin
          tos_d = nos_q;
          nos_d = tos_q;
          cnt_d = cnt_q + CNT_ONE;
          we    = 1'b1;
        end
      end
      default: ;
    endcase

    // Read-ahead from the post-op count; forward a same-cycle write to the same slot.
    ra    = cnt_d[AW-1:0] - AW'(3);
    rd_d  = (we && (wa == ra)) ? wd : mem[ra];

    hwm_d = sif.clr_flags ? cnt_d : ((cnt_d > hwm_q) ? cnt_d : hwm_q);
    ovf_d = (ovf_q & ~sif.clr_flags) | rej_o;
    unf_d = (unf_q & ~sif.clr_flags) | rej_u;
    err_d = rej_o | rej_u;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q <= '0;
      nos_q <= '0;
      cnt_q <= '0;
      hwm_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      nos_q <= nos_d;
      cnt_q <= cnt_d;
      hwm_q <= hwm_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= wd;
    rd_q <= rd_d;
  end

  assign sif.tos   = tos_q;
  assign sif.nos   = nos_q;
  assign sif.count = cnt_q;
  assign sif.hwm   = hwm_q;
  assign sif.ovf   = ovf_q;
  assign sif.unf   = unf_q;
  assign sif.err   = err_q;

endmodule

// File: tb/tb_cpu_stack_unit.sv
// Randomised and directed bench for two stack instances (DEPTH 256 and 4) against an array model.
module tb_cpu_stack_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_stack_if #(.DW(32), .DEPTH(256)) big_if ();
  cpu_stack_if #(.DW(32), .DEPTH(4))   sml_if ();

  cpu_stack_unit #(.DW(32), .DEPTH(256)) u_big (.clk(clk), .rst(rst), .sif(big_if.slave));
  cpu_stack_unit #(.DW(32), .DEPTH(4))   u_sml (.clk(clk), .rst(rst), .sif(sml_if.slave));

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                         POPR = 3'd4, SWAP = 3'd5, ROT = 3'd6, OVER = 3'd7;

  int nvec = 0;
  int nmis = 0;

  // Reference: plain array stack per instance, index 0 is the bottom entry.
  logic [31:0] mst   [2][256];
  int          mcnt  [2];
  int          mhwm  [2];
  bit          movf  [2];
  bit          munf  [2];
  bit          merr  [2];
  int          mdep  [2] = '{256, 4};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mcnt[s] = 0; mhwm[s] = 0; movf[s] = 0; munf[s] = 0; merr[s] = 0;
    end
  endtask

  task automatic model_op(input int s, input logic [2:0] op, input logic [31:0] din, input bit clr);
    int n;
    bit ro, ru;
    logic [31:0] t;
    n = mcnt[s]; ro = 0; ru = 0;
    case (op)
      PUSH: if (n == mdep[s]) ro = 1; else begin mst[s][n] = din; mcnt[s] = n + 1; end
      POP:  if (n < 1) ru = 1; else mcnt[s] = n - 1;
      REPL: if (n < 1) ru = 1; else mst[s][n-1] = din;
      POPR: if (n < 2) ru = 1; else begin mst[s][n-2] = din; mcnt[s] = n - 1; end
      SWAP: if (n < 2) ru = 1;
            else begin t = mst[s][n-1]; mst[s][n-1] = mst[s][n-2]; mst[s][n-2] = t; end
      ROT:  if (n < 3) ru = 1;
            else begin
              t = mst[s][n-3];
              mst[s][n-3] = mst[s][n-2];
              mst[s][n-2] = mst[s][n-1];
              mst[s][n-1] = t;
            end
      OVER: if (n < 2) ru = 1; else if (n == mdep[s]) ro = 1;
            else begin mst[s][n] = mst[s][n-2]; mcnt[s] = n + 1; end
      default: ;
    endcase
    movf[s] = (movf[s] && !clr) || ro;
    munf[s] = (munf[s] && !clr) || ru;
    merr[s] = ro || ru;
    mhwm[s] = clr ? mcnt[s] : ((mcnt[s] > mhwm[s]) ? mcnt[s] : mhwm[s]);
  endtask

  task automatic compare(input int s, input string tag);
    logic [31:0] g_tos, g_nos, g_cnt, g_hwm, e_tos, e_nos;
    logic g_ovf, g_unf, g_err;
    if (s == 0) begin
      g_tos = big_if.tos; g_nos = big_if.nos; g_cnt = 32'(big_if.count); g_hwm = 32'(big_if.hwm);
      g_ovf = big_if.ovf; g_unf = big_if.unf; g_err = big_if.err;
    end else begin
      g_tos = sml_if.tos; g_nos = sml_if.nos; g_cnt = 32'(sml_if.count); g_hwm = 32'(sml_if.hwm);
      g_ovf = sml_if.ovf; g_unf = sml_if.unf; g_err = sml_if.err;
    end
    e_tos = (mcnt[s] > 0) ? mst[s][mcnt[s]-1] : 32'd0;
    e_nos = (mcnt[s] > 1) ? mst[s][mcnt[s]-2] : 32'd0;
    chk({tag, ".tos"},   g_tos, e_tos);
    chk({tag, ".nos"},   g_nos, e_nos);
    chk({tag, ".count"}, g_cnt, 32'(mcnt[s]));
    chk({tag, ".hwm"},   g_hwm, 32'(mhwm[s]));
    chk({tag, ".ovf"},   32'(g_ovf), 32'(movf[s]));
    chk({tag, ".unf"},   32'(g_unf), 32'(munf[s]));
    chk({tag, ".err"},   32'(g_err), 32'(merr[s]));
  endtask

  // One clock: drive instance s (the other idles), optionally with rst, then compare.
  task automatic step(input int s, input logic [2:0] op, input logic [31:0] din,
                      input bit clr, input bit r, input string tag);
    @(negedge clk);
    big_if.op = NOP; big_if.din = '0; big_if.clr_flags = 1'b0;
    sml_if.op = NOP; sml_if.din = '0; sml_if.clr_flags = 1'b0;
    if (s == 0) begin big_if.op = op; big_if.din = din; big_if.clr_flags = clr; end
    else        begin sml_if.op = op; sml_if.din = din; sml_if.clr_flags = clr; end
    rst = r;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else begin
      model_op(s, op, din, clr);
      model_op(1 - s, NOP, 32'd0, 1'b0);
    end
    compare(s, tag);
  endtask

  task automatic rand_ops(input int s, input int n, input string tag);
    logic [2:0] op;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = PUSH;
      step(s, op, $urandom, ($urandom_range(0, 15) == 0), 1'b0, tag);
    end
  endtask

  initial begin
    big_if.op = NOP; big_if.din = '0; big_if.clr_flags = 1'b0;
    sml_if.op = NOP; sml_if.din = '0; sml_if.clr_flags = 1'b0;
    model_reset();

    step(0, NOP, 0, 0, 1, "rst_big");
    step(1, NOP, 0, 0, 1, "rst_sml");

    for (int i = 1; i <= 5; i++) step(0, PUSH, 32'(i), 0, 0, "t1_push");
    for (int i = 0; i < 5; i++)  step(0, POP, 0, 0, 0, "t1_pop");

    for (int i = 1; i <= 4; i++) step(1, PUSH, 32'(i), 0, 0, "t2_fill");
    step(1, PUSH, 32'd9, 0, 0, "t2_ovf");
    step(1, NOP, 0, 1, 0, "t2_clr");

    step(0, POP, 0, 0, 0, "t3_unf");
    step(0, NOP, 0, 0, 0, "t3_errdrop");
    step(0, PUSH, 32'd7, 1, 0, "t3_push");
    step(0, POP, 0, 0, 0, "t3_pop");

    for (int i = 1; i <= 3; i++) step(0, PUSH, 32'(i), 0, 0, "t4_push");
    step(0, ROT, 0, 0, 0, "t4_rot");
    for (int i = 0; i < 3; i++) step(0, POP, 0, 0, 0, "t4_pop");

    step(0, PUSH, 32'h1234, 0, 0, "t5_a");
    step(0, PUSH, 32'h0abc, 0, 0, "t5_b");
    step(0, POPR, 32'h1234 + 32'h0abc, 0, 0, "t5_popr");
    step(0, SWAP, 0, 0, 0, "t5_swap1");
    step(0, POP, 0, 0, 0, "t5_pop");

    rand_ops(1, 300, "rnd_sml");
    rand_ops(0, 400, "rnd_big");

    step(0, NOP, 0, 0, 1, "t6_rst0");
    for (int i = 0; i < 200; i++) step(0, PUSH, $urandom, 0, 0, "t6_fill");
    for (int i = 0; i < 60; i++) step(0, 3'($urandom_range(2, 7)), $urandom, 0, 0, "t6_deep");
    step(0, PUSH, 32'd5, 0, 1, "t6_rst");
    step(0, PUSH, 32'd3, 0, 0, "t6_push");
    rand_ops(0, 100, "rnd_tail");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
